// File: rtl/input_feature_quantizer.sv
// Streaming feature quantizer: assembles NUM_FEATURES raw beats into one registered sample.
// Optional macro QUANT_ROUND_EN selects round-to-nearest instead of truncation.
module input_feature_quantizer #(
    parameter int NUM_FEATURES = 49,
    parameter int FEAT_W       = 16,
    parameter int Q_BITS       = 2,
    parameter int SHIFT        = 4,
    parameter int OFFSET       = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [FEAT_W-1:0]              s_data,
    input  logic                           s_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [NUM_FEATURES*Q_BITS-1:0] m_data,
    output logic                           frame_err
);

    localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int OUT_W = NUM_FEATURES * Q_BITS;
    localparam int EXT_W = FEAT_W + 2;
    localparam int ROUND_BIAS = (SHIFT > 0) ? 2 ** (SHIFT - 1) : 0;
    localparam logic signed [EXT_W-1:0] Q_MAX    = EXT_W'((1 << Q_BITS) - 1);
    localparam logic        [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    typedef enum logic {ST_FILL, ST_WAIT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OUT_W-1:0]   asm_q, asm_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               mvalid_q, mvalid_d;
    logic               err_q, err_d;
    logic               alive_q;

    logic signed [FEAT_W:0]    diff;
    logic signed [EXT_W-1:0]   biased;
    logic signed [EXT_W-1:0]   shifted;
    logic        [Q_BITS-1:0]  qval;
    logic                      accept;
    logic                      at_last;
    logic                      handshake;

    // Extra headroom bit keeps the rounding bias from wrapping large positive inputs.
    always_comb begin
        diff   = $signed({s_data[FEAT_W-1], s_data}) - $signed((FEAT_W+1)'(OFFSET));
        biased = EXT_W'(diff);
`ifdef QUANT_ROUND_EN
        biased = biased + $signed(EXT_W'(ROUND_BIAS));
`endif
        shifted = biased >>> SHIFT;
        if (shifted < 0) begin
            qval = '0;
        end else if (shifted > Q_MAX) begin
            qval = '1;
        end else begin
            qval = shifted[Q_BITS-1:0];
        end
    end

    assign s_ready   = alive_q && (state_q == ST_FILL);
    assign accept    = s_valid && s_ready;
    assign at_last   = (idx_q == LAST_IDX);
    assign handshake = mvalid_q && m_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        asm_d    = asm_q;
        out_d    = out_q;
        mvalid_d = mvalid_q;
        err_d    = 1'b0;
        if (handshake) begin
            mvalid_d = 1'b0;
        end
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    asm_d[idx_q*Q_BITS +: Q_BITS] = qval;
                    if (s_last != at_last) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else if (at_last) begin
                        idx_d = '0;
                        // Completed sample goes straight out when the output slot frees this cycle.
                        if (!mvalid_q || m_ready) begin
                            out_d    = asm_d;
                            mvalid_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (handshake) begin
                    out_d    = asm_q;
                    mvalid_d = 1'b1;
                    idx_d    = '0;
                    state_d  = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FILL;
            idx_q    <= '0;
            asm_q    <= '0;
            out_q    <= '0;
            mvalid_q <= 1'b0;
            err_q    <= 1'b0;
            alive_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            asm_q    <= asm_d;
            out_q    <= out_d;
            mvalid_q <= mvalid_d;
            err_q    <= err_d;
            alive_q  <= 1'b1;
        end
    end

    assign m_valid   = mvalid_q;
    assign m_data    = out_q;
    assign frame_err = err_q;

endmodule
